// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq
//  Description : Sequential 32x32 -> 64-bit multiplier for the hi/lo unit of
//                a MIPS-style pipeline. Handles mult (signed) and multu
//                (unsigned) with a fixed 34-cycle accept-to-result latency.
//                Signed operands are reduced to magnitudes, multiplied one
//                multiplier bit per cycle with a shift-add accumulator, and
//                the sign is reapplied when the product is loaded into hi/lo.
//                Generates a pipeline stall for hi/lo readers and for new
//                requests while a multiply is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          C_WIDTH    = 32;
    localparam logic [4:0]  C_LAST_CNT = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;

    logic [C_WIDTH-1:0]     r_mcand;     // |a| latched at accept
    logic [C_WIDTH-1:0]     r_mplier;    // |b|, consumed LSB first
    logic [2*C_WIDTH-1:0]   r_acc;       // running partial product
    logic [4:0]             r_cnt;       // multiplier bits processed so far
    logic                   r_neg;       // final product must be negated
    logic [C_WIDTH-1:0]     r_hi;
    logic [C_WIDTH-1:0]     r_lo;
    logic                   r_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                   w_accept;    // IDLE edge that takes a new request
    logic                   w_last;      // RUN edge on the final multiplier bit
    logic [C_WIDTH-1:0]     w_a_mag;
    logic [C_WIDTH-1:0]     w_b_mag;
    logic                   w_neg;
    logic [C_WIDTH-1:0]     w_addend;
    logic [C_WIDTH:0]       w_sum;       // upper half plus addend, carry kept
    logic [2*C_WIDTH-1:0]   w_acc_step;
    logic [2*C_WIDTH-1:0]   w_prod;

    // Operand magnitudes: only mult treats bit 31 as a sign. Negating
    // 0x80000000 yields 0x80000000, which read as unsigned is exactly 2^31.
    assign w_a_mag = (signed_op && a[C_WIDTH-1]) ? (~a + 32'd1) : a;
    assign w_b_mag = (signed_op && b[C_WIDTH-1]) ? (~b + 32'd1) : b;
    assign w_neg   = signed_op & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the 65-bit {carry, upper, lower} right by one.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*C_WIDTH-1:C_WIDTH]} + {1'b0, w_addend};
    assign w_acc_step = {w_sum, r_acc[C_WIDTH-1:1]};

    // Sign is applied once at the end; a zero magnitude product stays zero
    // because the two's-complement negation of zero is zero.
    assign w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;

    // ------------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == C_LAST_CNT) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and shift-add iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_neg;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_step;
            r_mplier <= {1'b0, r_mplier[C_WIDTH-1:1]};
            r_cnt    <= r_cnt + 5'd1;
        end
    end

    // Result registers: hi/lo move only when a completed product is retired
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_DONE) begin
                r_hi   <= w_prod[2*C_WIDTH-1:C_WIDTH];
                r_lo   <= w_prod[C_WIDTH-1:0];
                r_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // busy comes straight from the state register, so it is glitch-free.
    // The stall only matters while a multiply is in flight: a new request
    // must be held back, and a hi/lo read would otherwise see stale data.
    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | rd_hilo);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

    // w_last is decoded for readability of the sequencer; the transition
    // itself is carried by w_state_next.
    logic w_unused;
    assign w_unused = w_last;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq
//  Description : Self-checking bench for mult_seq. Directed and random
//                multiplies are compared against an arithmetic product
//                model; hazard, back-to-back and reset scenarios are checked
//                cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hilo;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .rd_hilo   (rd_hilo),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference: the exact 64-bit product by plain arithmetic
    function automatic logic [63:0] ref_product(input logic [31:0] x,
                                                input logic [31:0] y,
                                                input logic        s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            sp = sx * sy;
            return sp;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one multiply from IDLE and observe it; returns the product seen
    // after edge 33, the number of busy cycles, and whether done/hi/lo
    // behaved (no early done or hi/lo change, done exactly one cycle).
    task automatic exec_op(input  logic [31:0] x,
                           input  logic [31:0] y,
                           input  logic        s,
                           output logic [63:0] res,
                           output int          bcnt,
                           output bit          clean);
        logic [63:0] prev;
        bit          bad;
        prev = {hi, lo};
        bad  = 0;
        bcnt = 0;
        a = x; b = y; signed_op = s; start = 1'b1;
        for (int e = 0; e <= 32; e++) begin
            tick();
            start = 1'b0;
            if (busy === 1'b1) bcnt++;
            if (done !== 1'b0 || {hi, lo} !== prev) bad = 1;
        end
        tick();
        res = {hi, lo};
        if (done !== 1'b1 || busy !== 1'b0) bad = 1;
        tick();
        if (done !== 1'b0) bad = 1;
        clean = !bad;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, stall, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/stall/done=%b required 000", {busy, stall, done});
        end
        n_checks++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h required 0", {hi, lo});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] vb [8] = '{32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'hFFFFFFFB, 32'h00000001, 32'h80000000};
        logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [63:0] ve [8] = '{64'h00000000_0000000F, 64'hFFFFFFFF_FFFFFFF1,
                                64'hFFFFFFFE_00000001, 64'h00000000_00000001,
                                64'h40000000_00000000, 64'h00000000_00000000,
                                64'hFFFFFFFF_80000000, 64'hC0000000_80000000};
        logic [63:0] res;
        int          bcnt;
        bit          clean;
        for (int i = 0; i < 8; i++) begin
            exec_op(va[i], vb[i], vs[i], res, bcnt, clean);
            n_checks++;
            if (res !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_%0d product: got %h required %h", i, res, ve[i]);
            end
            n_checks++;
            if (bcnt !== 33) begin
                n_fail++;
                $display("FAIL directed_%0d busy_cycles: got %0d required 33", i, bcnt);
            end
            n_checks++;
            if (!clean) begin
                n_fail++;
                $display("FAIL directed_%0d done_timing: got irregular done/hilo required one pulse after edge 33", i);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        logic [63:0] res;
        logic [63:0] exp;
        int          bcnt;
        bit          clean;
        for (int i = 0; i < 24; i++) begin
            x = $urandom();
            y = $urandom();
            s = 1'($urandom_range(0, 1));
            if (i % 6 == 5) x = 32'h80000000;
            if (i % 8 == 7) y = 32'd0;
            exp = ref_product(x, y, s);
            exec_op(x, y, s, res, bcnt, clean);
            n_checks++;
            if (res !== exp || !clean) begin
                n_fail++;
                $display("FAIL random_%0d %h*%h s=%b: got %h clean=%0d required %h clean=1",
                         i, x, y, s, res, clean, exp);
            end
        end
    endtask

    task automatic test_hazard_read();
        logic [63:0] exp;
        int          bad_stall;
        a = 32'h12345678; b = 32'h9ABCDEF0; signed_op = 1'b1;
        exp = ref_product(a, b, 1'b1);
        start = 1'b1; rd_hilo = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_start_read_stall: got %b required 0", stall);
        end
        bad_stall = 0;
        for (int e = 0; e <= 32; e++) begin
            tick();
            start = 1'b0;
            if (stall !== 1'b1) bad_stall++;
        end
        n_checks++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL read_stall_busy: got %0d cycles without stall required 0", bad_stall);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0 || done !== 1'b1 || {hi, lo} !== exp) begin
            n_fail++;
            $display("FAIL read_done_cycle: stall=%b done=%b hilo=%h required 0 1 %h",
                     stall, done, {hi, lo}, exp);
        end
        tick();
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_done_stall: got %b required 0", stall);
        end
        rd_hilo = 1'b0;
    endtask

    task automatic test_hazard_start();
        logic [63:0] exp1;
        logic [63:0] exp2;
        int          bad;
        exp1 = ref_product(32'hDEADBEEF, 32'h00001234, 1'b0);
        exp2 = ref_product(32'hF0000001, 32'h7FFF0003, 1'b1);
        a = 32'hDEADBEEF; b = 32'h00001234; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        a = 32'hF0000001; b = 32'h7FFF0003; signed_op = 1'b1; start = 1'b1;
        bad = 0;
        #1;
        if (stall !== 1'b1) bad++;
        for (int e = 5; e <= 32; e++) begin
            tick();
            if (stall !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL start_busy_stall: got %0d cycles without stall required 0", bad);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || {hi, lo} !== exp1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL first_result_kept: done=%b hilo=%h stall=%b required 1 %h 0",
                     done, {hi, lo}, stall, exp1);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL second_accepted: busy=%b required 1", busy);
        end
        for (int e = 35; e <= 66; e++) tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || {hi, lo} !== exp2) begin
            n_fail++;
            $display("FAIL second_result: done=%b hilo=%h required 1 %h", done, {hi, lo}, exp2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp1;
        logic [63:0] exp2;
        int          bad;
        exp1 = ref_product(32'h0000FFFF, 32'h00010001, 1'b0);
        exp2 = ref_product(32'hFFFFFF00, 32'h00000100, 1'b1);
        a = 32'h0000FFFF; b = 32'h00010001; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 33; e++) tick();
        n_checks++;
        if (done !== 1'b1 || {hi, lo} !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b hilo=%h required 1 %h", done, {hi, lo}, exp1);
        end
        a = 32'hFFFFFF00; b = 32'h00000100; signed_op = 1'b1; start = 1'b1;
        bad = 0;
        for (int e = 34; e <= 66; e++) begin
            tick();
            start = 1'b0;
            if ({hi, lo} !== exp1 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_hold: got %0d cycles with changed hilo or idle required 0", bad);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || {hi, lo} !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b hilo=%h required 1 %h", done, {hi, lo}, exp2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          bcnt;
        bit          clean;
        int          bad;
        a = 32'h00ABCDEF; b = 32'h00012345; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        rd_hilo = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, stall, done} !== 3'b000 || {hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy/stall/done=%b hilo=%h required 000 0",
                     {busy, stall, done}, {hi, lo});
        end
        bad = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got %0d active cycles required 0", bad);
        end
        rd_hilo = 1'b0;
        exec_op(32'h00000007, 32'hFFFFFFFA, 1'b1, res, bcnt, clean);
        n_checks++;
        if (res !== 64'hFFFFFFFF_FFFFFFD6 || !clean || bcnt !== 33) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h clean=%0d busy=%0d required ffffffffffffffd6 1 33",
                     res, clean, bcnt);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; signed_op = 1'b0;
        a = '0; b = '0; rd_hilo = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hazard_read();
        test_hazard_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
